// File: rtl/branch_sequencer.sv
// Fetch/decode/execute control sequencer for an LC-3 subset (ADD, AND, NOT, BR, JMP).
// Moore machine: every strobe and mux select decodes from registered state only.
module branch_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic        SR1MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_OE,
    output logic        Halted
);

    localparam logic [3:0] S_HALTED  = 4'd0;
    localparam logic [3:0] S_FETCH1  = 4'd1;
    localparam logic [3:0] S_FETCH2  = 4'd2;
    localparam logic [3:0] S_FETCH3  = 4'd3;
    localparam logic [3:0] S_DECODE  = 4'd4;
    localparam logic [3:0] S_ALU_OP  = 4'd5;
    localparam logic [3:0] S_NOT_OP  = 4'd6;
    localparam logic [3:0] S_BR_CHK  = 4'd7;
    localparam logic [3:0] S_BR_TAKE = 4'd8;
    localparam logic [3:0] S_JMP_EX  = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] wait_cnt;
    logic       wait_last;
    logic       alu_is_and;
    logic [3:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = IR[15:12];
    assign wait_last      = (wait_cnt == WAIT_LAST);
    assign unused_ir_bits = ^IR[11:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_HALTED;
            wait_cnt   <= 4'd0;
            alu_is_and <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FETCH1) begin
                wait_cnt <= 4'd0;
            end else if (state == S_FETCH2) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            // Capture the ALU flavour at decode so ALUK never depends on the live IR input.
            if (state == S_DECODE) begin
                alu_is_and <= (opcode == OP_AND);
            end
        end
    end

    always_comb begin
        state_next = S_HALTED;
        case (state)
            S_HALTED:  state_next = Run ? S_FETCH1 : S_HALTED;
            S_FETCH1:  state_next = S_FETCH2;
            S_FETCH2:  state_next = wait_last ? S_FETCH3 : S_FETCH2;
            S_FETCH3:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND: state_next = S_ALU_OP;
                    OP_NOT:         state_next = S_NOT_OP;
                    OP_BR:          state_next = S_BR_CHK;
                    OP_JMP:         state_next = S_JMP_EX;
                    default:        state_next = S_DONE;
                endcase
            end
            S_ALU_OP:  state_next = S_DONE;
            S_NOT_OP:  state_next = S_DONE;
            S_BR_CHK:  state_next = BEN ? S_BR_TAKE : S_DONE;
            S_BR_TAKE: state_next = S_DONE;
            S_JMP_EX:  state_next = S_DONE;
            S_DONE:    state_next = Run ? S_FETCH1 : S_HALTED;
            default:   state_next = S_HALTED;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        SR1MUX     = 1'b0;
        ALUK       = 2'b00;
        Mem_OE     = 1'b0;
        Halted     = 1'b0;
        case (state)
            S_HALTED: Halted = 1'b1;
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_FETCH2: begin
                Mem_OE = 1'b1;
                LD_MDR = wait_last;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ALU_OP: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = alu_is_and ? 2'b01 : 2'b00;
            end
            S_NOT_OP: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = 2'b10;
            end
            // PC + sext(offset9)
            S_BR_TAKE: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b10;
                ADDR2MUX = 2'b10;
            end
            // BaseR + 0, with BaseR read through SR1 from IR[8:6]
            S_JMP_EX: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b10;
                ADDR1MUX = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: per-cycle output vectors checked against an
// instruction-level model of the fetch/decode/execute timeline.
module tb_branch_sequencer;

  localparam logic [20:0] M_LD_MAR      = 21'd1 << 20;
  localparam logic [20:0] M_LD_MDR      = 21'd1 << 19;
  localparam logic [20:0] M_LD_IR       = 21'd1 << 18;
  localparam logic [20:0] M_LD_BEN      = 21'd1 << 17;
  localparam logic [20:0] M_LD_CC       = 21'd1 << 16;
  localparam logic [20:0] M_LD_REG      = 21'd1 << 15;
  localparam logic [20:0] M_LD_PC       = 21'd1 << 14;
  localparam logic [20:0] M_GATE_PC     = 21'd1 << 13;
  localparam logic [20:0] M_GATE_MDR    = 21'd1 << 12;
  localparam logic [20:0] M_GATE_ALU    = 21'd1 << 11;
  localparam logic [20:0] M_PCMUX_ADDER = 21'd2 << 8;
  localparam logic [20:0] M_ADDR1_SR1   = 21'd1 << 7;
  localparam logic [20:0] M_ADDR2_OFF9  = 21'd2 << 5;
  localparam logic [20:0] M_ALUK_AND    = 21'd1 << 2;
  localparam logic [20:0] M_ALUK_NOT    = 21'd2 << 2;
  localparam logic [20:0] M_MEM_OE      = 21'd1 << 1;
  localparam logic [20:0] M_HALTED      = 21'd1;
  localparam logic [20:0] M_NONE        = 21'd0;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] IR;
  logic        BEN;
  wire  [20:0] obs1;
  wire  [20:0] obs2;

  int n_asserts = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  branch_sequencer #(.MEM_WAIT(2)) dut_w2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .IR(IR), .BEN(BEN),
    .LD_MAR(obs1[20]), .LD_MDR(obs1[19]), .LD_IR(obs1[18]), .LD_BEN(obs1[17]),
    .LD_CC(obs1[16]), .LD_REG(obs1[15]), .LD_PC(obs1[14]),
    .GatePC(obs1[13]), .GateMDR(obs1[12]), .GateALU(obs1[11]), .GateMARMUX(obs1[10]),
    .PCMUX(obs1[9:8]), .ADDR1MUX(obs1[7]), .ADDR2MUX(obs1[6:5]), .SR1MUX(obs1[4]),
    .ALUK(obs1[3:2]), .Mem_OE(obs1[1]), .Halted(obs1[0])
  );

  branch_sequencer #(.MEM_WAIT(5)) dut_w5 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .IR(IR), .BEN(BEN),
    .LD_MAR(obs2[20]), .LD_MDR(obs2[19]), .LD_IR(obs2[18]), .LD_BEN(obs2[17]),
    .LD_CC(obs2[16]), .LD_REG(obs2[15]), .LD_PC(obs2[14]),
    .GatePC(obs2[13]), .GateMDR(obs2[12]), .GateALU(obs2[11]), .GateMARMUX(obs2[10]),
    .PCMUX(obs2[9:8]), .ADDR1MUX(obs2[7]), .ADDR2MUX(obs2[6:5]), .SR1MUX(obs2[4]),
    .ALUK(obs2[3:2]), .Mem_OE(obs2[1]), .Halted(obs2[0])
  );

  // reference model: one instruction from FETCH1 through DONE, one vector per cycle
  task automatic model_push(input logic [15:0] ir, input logic ben, input int w);
    logic [3:0] op;
    op = ir[15:12];
    exp_q.push_back(M_GATE_PC | M_LD_MAR | M_LD_PC);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back(M_MEM_OE | ((i == w - 1) ? M_LD_MDR : M_NONE));
    end
    exp_q.push_back(M_GATE_MDR | M_LD_IR);
    exp_q.push_back(M_LD_BEN);
    case (op)
      4'h1: exp_q.push_back(M_GATE_ALU | M_LD_REG | M_LD_CC);
      4'h5: exp_q.push_back(M_GATE_ALU | M_LD_REG | M_LD_CC | M_ALUK_AND);
      4'h9: exp_q.push_back(M_GATE_ALU | M_LD_REG | M_LD_CC | M_ALUK_NOT);
      4'h0: begin
        exp_q.push_back(M_NONE);
        if (ben) exp_q.push_back(M_LD_PC | M_PCMUX_ADDER | M_ADDR2_OFF9);
      end
      4'hC: exp_q.push_back(M_LD_PC | M_PCMUX_ADDER | M_ADDR1_SR1);
      default: ;
    endcase
    exp_q.push_back(M_NONE);
  endtask

  // driver tasks
  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0;
    IR = 16'h0000;
    BEN = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic issue(input logic [15:0] ir, input logic ben, input int w);
    IR = ir;
    BEN = ben;
    model_push(ir, ben, w);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_asserts++;
      if (obs1 !== M_HALTED) begin
        n_fail++;
        $display("FAIL reset_idle_w2: cycle %0d got %06h want %06h", i, obs1, M_HALTED);
      end
      n_asserts++;
      if (obs2 !== M_HALTED) begin
        n_fail++;
        $display("FAIL reset_idle_w5: cycle %0d got %06h want %06h", i, obs2, M_HALTED);
      end
      @(negedge Clk);
    end
    Run = 1'b1;
    IR = 16'h1042;
    @(negedge Clk);
    @(negedge Clk);
    n_asserts++;
    if (obs1 !== M_MEM_OE) begin
      n_fail++;
      $display("FAIL reset_pre_fetch2: got %06h want %06h", obs1, M_MEM_OE);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_asserts++;
    if (obs1 !== M_HALTED) begin
      n_fail++;
      $display("FAIL reset_mid_fetch2_w2: got %06h want %06h", obs1, M_HALTED);
    end
    n_asserts++;
    if (obs2 !== M_HALTED) begin
      n_fail++;
      $display("FAIL reset_mid_fetch2_w5: got %06h want %06h", obs2, M_HALTED);
    end
    Reset = 1'b0;
    Run = 1'b0;
    @(negedge Clk);
    n_asserts++;
    if (obs1 !== M_HALTED) begin
      n_fail++;
      $display("FAIL reset_release_halted: got %06h want %06h", obs1, M_HALTED);
    end
  endtask

  task automatic test_add_back_to_back();
    logic [20:0] e;
    do_reset();
    Run = 1'b1;
    issue(16'h1042, 1'b0, 2);
    issue(16'h1042, 1'b0, 2);
    n_asserts++;
    if (exp_q.size() != 14) begin
      n_fail++;
      $display("FAIL add_model_len: got %0d want 14", exp_q.size());
    end
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      n_asserts++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL add_seq: t=%0t got %06h want %06h", $time, obs1, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    logic [15:0] ir_list[8];
    logic        ben_list[8];
    logic [31:0] r;
    ir_list[0] = 16'h0E05; ben_list[0] = 1'b1;
    ir_list[1] = 16'h0E05; ben_list[1] = 1'b0;
    for (int i = 2; i < 8; i++) begin
      r = $urandom();
      ir_list[i] = {4'b0000, r[11:0]};
      ben_list[i] = r[16];
    end
    do_reset();
    Run = 1'b1;
    for (int n = 0; n < 8; n++) begin
      issue(ir_list[n], ben_list[n], 2);
      while (exp_q.size() > 0) begin
        @(negedge Clk);
        e = exp_q.pop_front();
        n_asserts++;
        if (obs1 !== e) begin
          n_fail++;
          $display("FAIL branch_seq: ir=%04h ben=%0b got %06h want %06h",
                   ir_list[n], ben_list[n], obs1, e);
        end
      end
    end
  endtask

  task automatic test_jmp_alu_nop();
    logic [20:0] e;
    logic [15:0] ir_list[4];
    ir_list[0] = 16'hC1C0;
    ir_list[1] = 16'h5020;
    ir_list[2] = 16'h903F;
    ir_list[3] = 16'hF025;
    do_reset();
    Run = 1'b1;
    for (int n = 0; n < 4; n++) begin
      issue(ir_list[n], 1'b1, 2);
      while (exp_q.size() > 0) begin
        @(negedge Clk);
        e = exp_q.pop_front();
        n_asserts++;
        if (obs1 !== e) begin
          n_fail++;
          $display("FAIL jmp_alu_nop_seq: ir=%04h got %06h want %06h", ir_list[n], obs1, e);
        end
      end
    end
  endtask

  task automatic test_run_drop();
    logic [20:0] e;
    int k;
    do_reset();
    Run = 1'b1;
    issue(16'h1042, 1'b0, 2);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      n_asserts++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL run_drop_seq: step %0d got %06h want %06h", k, obs1, e);
      end
      if (k == 5) Run = 1'b0;
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_asserts++;
      if (obs1 !== M_HALTED) begin
        n_fail++;
        $display("FAIL run_drop_halted: cycle %0d got %06h want %06h", i, obs1, M_HALTED);
      end
    end
    Run = 1'b1;
    issue(16'h5020, 1'b0, 2);
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      n_asserts++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL run_restart_seq: got %06h want %06h", obs1, e);
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] e;
    logic [31:0] r;
    logic [15:0] ir;
    do_reset();
    Run = 1'b1;
    for (int n = 0; n < 30; n++) begin
      r = $urandom();
      ir = {4'($urandom_range(0, 15)), r[11:0]};
      issue(ir, r[20], 2);
      while (exp_q.size() > 0) begin
        @(negedge Clk);
        e = exp_q.pop_front();
        n_asserts++;
        if (obs1 !== e) begin
          n_fail++;
          $display("FAIL random_seq: ir=%04h ben=%0b got %06h want %06h", ir, r[20], obs1, e);
        end
        n_asserts++;
        if ($countones(obs1[13:10]) > 1) begin
          n_fail++;
          $display("FAIL gate_onehot: ir=%04h got gates %04b want at most one high", ir, obs1[13:10]);
        end
        n_asserts++;
        if (obs1[17] && obs1[16]) begin
          n_fail++;
          $display("FAIL cc_ben_overlap: ir=%04h got LD_BEN=1 LD_CC=1 want not both", ir);
        end
      end
    end
  endtask

  task automatic test_mem_wait5();
    logic [20:0] e;
    logic [31:0] r;
    logic [15:0] ir;
    do_reset();
    Run = 1'b1;
    for (int n = 0; n < 6; n++) begin
      r = $urandom();
      ir = (n == 0) ? 16'h1042 : {4'($urandom_range(0, 15)), r[11:0]};
      issue(ir, r[24], 5);
      while (exp_q.size() > 0) begin
        @(negedge Clk);
        e = exp_q.pop_front();
        n_asserts++;
        if (obs2 !== e) begin
          n_fail++;
          $display("FAIL wait5_seq: ir=%04h got %06h want %06h", ir, obs2, e);
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    IR = 16'h0000;
    BEN = 1'b0;
    test_reset();
    test_add_back_to_back();
    test_branch();
    test_jmp_alu_nop();
    test_run_drop();
    test_random();
    test_mem_wait5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control sequencer for the datapath's condition-code and branch-enable register. It drives LD_CC and LD_BEN and consumes BEN.
- Runs the fetch/decode loop for a subset of the LC-3 ISA: ADD, AND, NOT, BR and JMP.
- Emits all datapath load, gate and mux-select strobes, and waits a fixed number of cycles for memory reads.
- All other opcodes execute as NOPs.

Parameters:
- MEM_WAIT, 2: number of cycles FETCH2 holds Mem_OE before MDR is loaded. Legal range is 1..15.

Ports:
- Clk, input, 1: clock. Everything updates on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- Run, input, 1: starts execution from HALTED. It is sampled at every instruction boundary.
- IR, input, 16: current instruction register contents.
- BEN, input, 1: branch enable from the CC/BEN block.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, output, 1 each: register load strobes.
- GatePC, GateMDR, GateALU, GateMARMUX, output, 1 each: bus drivers. At most one is high in any state.
- PCMUX, output, 2: PC source. 00 = PC+1, 01 = bus, 10 = address adder.
- ADDR1MUX, output, 1: adder base. 0 = PC, 1 = SR1 output.
- ADDR2MUX, output, 2: adder offset. 00 = zero, 01 = sext offset6, 10 = sext offset9, 11 = sext offset11.
- SR1MUX, output, 1: 0 = IR[8:6], 1 = IR[11:9].
- ALUK, output, 2: ALU operation. 00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA.
- Mem_OE, output, 1: memory read enable, active-high.
- Halted, output, 1: high while in HALTED.

Behaviour:
- Moore machine. All outputs decode from the registered state only, with no input-to-output combinational path. Any strobe not listed for a state is 0.
- Default mux selects are 00/0 everywhere except where a state lists otherwise.
- Reset: state becomes HALTED and the wait counter clears. Every strobe, gate and Mem_OE is 0, all mux selects are 0, and Halted = 1.
  - Reset has priority over every transition, including mid-instruction and mid-wait.
- HALTED: Halted = 1. If Run = 1, go to FETCH1; otherwise stay.
- FETCH1:
  - Outputs: GatePC, LD_MAR, LD_PC, PCMUX = 00. MAR gets PC, PC gets PC+1.
  - Next state: FETCH2, with the wait counter loaded to 0.
- FETCH2:
  - Outputs: Mem_OE = 1.
  - Counter increments each cycle. When counter == MEM_WAIT-1, LD_MDR = 1 in that same cycle and the next state is FETCH3.
  - The state is held for exactly MEM_WAIT cycles.
- FETCH3:
  - Outputs: GateMDR, LD_IR.
  - Next state: DECODE.
- DECODE:
  - Outputs: LD_BEN. BEN gets the new value at the end of this cycle.
  - Next state by IR[15:12]: 0001 or 0101 goes to ALU_OP; 1001 goes to NOT_OP; 0000 goes to BR_CHK; 1100 goes to JMP_EX; anything else goes to DONE.
- ALU_OP:
  - Outputs: GateALU, LD_REG, LD_CC, SR1MUX = 0.
  - ALUK = 00 if IR[15:12] = 0001, and 01 if 0101.
  - Immediate versus register operand is selected in the datapath by IR[5]; this block ignores IR[5].
  - Next state: DONE.
- NOT_OP:
  - Outputs: GateALU, LD_REG, LD_CC, ALUK = 10, SR1MUX = 0.
  - Next state: DONE.
- BR_CHK:
  - No strobes. BEN is valid here because it was loaded in DECODE.
  - BEN = 1 goes to BR_TAKE; BEN = 0 goes to DONE.
- BR_TAKE:
  - Outputs: LD_PC, PCMUX = 10, ADDR1MUX = 0, ADDR2MUX = 10.
  - Next state: DONE.
- JMP_EX:
  - Outputs: LD_PC, PCMUX = 10, ADDR1MUX = 1, ADDR2MUX = 00, SR1MUX = 0 (BaseR is IR[8:6]).
  - Next state: DONE.
- DONE:
  - No strobes. This is the instruction boundary.
  - Run = 1 goes to FETCH1; Run = 0 goes to HALTED.
- Latency in cycles, with W = MEM_WAIT:
  - ALU/NOT: 5+W.
  - Taken BR: 6+W.
  - Not-taken BR: 5+W.
  - JMP: 5+W.
  - NOP: 4+W.
- Run is ignored mid-instruction. Dropping Run halts only at DONE.
- LD_CC and LD_BEN are never high in the same cycle. LD_CC is high only in ALU_OP and NOT_OP.
- Unreachable state encodings return to HALTED on the next cycle.

Test Plan:
- Reset, then Run = 0 for 5 cycles: Halted = 1, all strobes 0, no Mem_OE pulses. Assert Reset mid-FETCH2: HALTED on the next cycle.
- MEM_WAIT = 2, IR = 0x1042 (ADD), Run held at 1: FETCH1 with LD_PC and GatePC, then Mem_OE for 2 cycles with LD_MDR in the 2nd, then LD_IR, then LD_BEN, then GateALU + LD_REG + LD_CC with ALUK = 00, then DONE, then FETCH1. Total 7 cycles.
- IR = 0x0E05 (BRnzp) with BEN = 1 in BR_CHK: BR_TAKE asserts LD_PC, PCMUX = 10, ADDR2MUX = 10, ADDR1MUX = 0. Repeat with BEN = 0: LD_PC is never asserted after FETCH1.
- IR = 0xC1C0 (JMP R7): JMP_EX asserts LD_PC, PCMUX = 10, ADDR1MUX = 1, ADDR2MUX = 00. LD_CC stays 0 throughout.
- IR = 0x5020 (AND) gives ALUK = 01; IR = 0x903F (NOT) gives ALUK = 10. IR = 0xF025 (TRAP) passes DECODE straight to DONE with no LD_REG, LD_CC or LD_PC beyond the fetch.
- Drop Run during ALU_OP: the instruction completes, DONE goes to HALTED, Halted = 1. Raise Run again: FETCH1 on the next cycle. Check one-hot gates across all states, and repeat the ADD sequence with MEM_WAIT = 5 (5 Mem_OE cycles).
